// File: rtl/ramlpm_sp32x8.sv
// ramlpm_sp32x8: 32x8 single-port synchronous RAM with two register stages.
// Stage 1 registers address/data/wren; stage 2 registers q. A registered
// write commits to the array on the following edge and is echoed on q in the
// same edge (new-data mode). Because commit and the next read's array lookup
// happen on successive edges, a read registered right after a write sees the
// written word directly from the array, so no bypass mux is needed.
module ramlpm_sp32x8 #(
    parameter int    ADDR_W   = 5,
    parameter int    DATA_W   = 8,
    parameter string INIT_HEX = ""
) (
    input  logic [ADDR_W-1:0] address,
    input  logic              clock,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    input  logic              reset
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    // Power-up image: all zeros.
    function automatic mem_t f_init();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        return m;
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH] = f_init();

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_wren;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_rd;
    logic              w_commit;

    assign w_rd     = r_mem[r_addr];
    // Reset on the commit edge drops a registered write.
    assign w_commit = r_wren & ~reset;
    assign q        = r_q;

    // Array write: commit the registered write one edge after capture.
    always_ff @(posedge clock) begin
        if (w_commit) r_mem[r_addr] <= r_data;
    end

    // Input registers and output register; reset clears all, not the array.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr <= '0;
            r_data <= '0;
            r_wren <= 1'b0;
            r_q    <= '0;
        end else begin
            r_addr <= address;
            r_data <= data;
            r_wren <= wren;
            r_q    <= r_wren ? r_data : w_rd;
        end
    end

endmodule

// File: tb/tb_ramlpm_sp32x8.sv
// Testbench for ramlpm_sp32x8: directed vector table, a streaming sequence,
// and randomized traffic checked against a transaction-level memory model.
module tb_ramlpm_sp32x8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] address = '0;
    logic [7:0] data = '0;
    logic       wren = 1'b0;
    logic [7:0] q;

    int n_cmp  = 0;
    int n_fail = 0;

    ramlpm_sp32x8 dut (
        .address (address),
        .clock   (clock),
        .data    (data),
        .wren    (wren),
        .q       (q),
        .reset   (reset)
    );

    always #5 clock = ~clock;

    // Reference model: a plain array plus a queue of accepted requests.
    // A request accepted at one edge takes effect at the next edge.
    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        logic       w;
    } req_t;

    logic [7:0] m_mem [32];
    req_t       m_pend [$];
    logic [7:0] m_q;

    task automatic model_edge(input logic [4:0] a, input logic [7:0] d,
                              input logic w, input logic rst);
        req_t r;
        r = m_pend.pop_front();
        if (rst) begin
            m_q = 8'h00;
            m_pend.push_back('{a: 5'd0, d: 8'h00, w: 1'b0});
        end else begin
            if (r.w) begin
                m_mem[r.a] = r.d;
                m_q = r.d;
            end else begin
                m_q = m_mem[r.a];
            end
            m_pend.push_back('{a: a, d: d, w: w});
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: q=%02h expected %02h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance one edge, compare q to the model.
    task automatic step(input logic [4:0] a, input logic [7:0] d,
                        input logic w, input logic rst, input string name);
        address = a; data = d; wren = w; reset = rst;
        @(posedge clock);
        model_edge(a, d, w, rst);
        #1;
        check(name, q, m_q);
    endtask

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        logic       w;
        logic       rst;
        logic [7:0] exp_q;
        string      name;
    } vec_t;

    vec_t vt [$];

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
        m_q = 8'h00;
        m_pend.push_back('{a: 5'd0, d: 8'h00, w: 1'b0});

        // Directed vectors; exp_q is q right after the row's edge.
        vt.push_back('{5'd0,  8'h00, 1'b0, 1'b1, 8'h00, "reset0"});
        vt.push_back('{5'd0,  8'h00, 1'b0, 1'b1, 8'h00, "reset1"});
        vt.push_back('{5'd5,  8'hA5, 1'b1, 1'b0, 8'h00, "wr5_cap"});
        vt.push_back('{5'd5,  8'h00, 1'b0, 1'b0, 8'hA5, "wr5_echo"});
        vt.push_back('{5'd0,  8'h00, 1'b0, 1'b0, 8'hA5, "rd5_lat2"});
        vt.push_back('{5'd3,  8'h5A, 1'b1, 1'b0, 8'h00, "wr3_cap"});
        vt.push_back('{5'd7,  8'h11, 1'b1, 1'b0, 8'h5A, "wr3_echo"});
        vt.push_back('{5'd7,  8'h00, 1'b0, 1'b0, 8'h11, "wr7_echo"});
        vt.push_back('{5'd3,  8'h00, 1'b0, 1'b0, 8'h11, "rd7_fwd"});
        vt.push_back('{5'd0,  8'h00, 1'b0, 1'b0, 8'h5A, "rd3_mem"});
        vt.push_back('{5'd0,  8'hFF, 1'b1, 1'b0, 8'h00, "rd0_zero"});
        vt.push_back('{5'd31, 8'h00, 1'b1, 1'b0, 8'hFF, "wr0_echo"});
        vt.push_back('{5'd31, 8'h00, 1'b0, 1'b0, 8'h00, "wr31_echo"});
        vt.push_back('{5'd0,  8'h00, 1'b0, 1'b0, 8'h00, "rd31_00"});
        vt.push_back('{5'd1,  8'h00, 1'b0, 1'b0, 8'hFF, "rd0_FF"});
        vt.push_back('{5'd30, 8'h00, 1'b0, 1'b0, 8'h00, "rd1_nb"});
        vt.push_back('{5'd31, 8'hFF, 1'b1, 1'b0, 8'h00, "rd30_nb"});
        vt.push_back('{5'd0,  8'h00, 1'b0, 1'b0, 8'hFF, "wr31_FF"});
        vt.push_back('{5'd31, 8'h00, 1'b0, 1'b0, 8'hFF, "rd0_keep"});
        vt.push_back('{5'd30, 8'h00, 1'b0, 1'b0, 8'hFF, "rd31_FF"});
        vt.push_back('{5'd0,  8'h00, 1'b0, 1'b0, 8'h00, "rd30_keep"});
        vt.push_back('{5'd9,  8'hFF, 1'b1, 1'b0, 8'hFF, "wr9_cap"});
        vt.push_back('{5'd8,  8'h00, 1'b0, 1'b0, 8'hFF, "wr9_echo"});
        vt.push_back('{5'd9,  8'h42, 1'b1, 1'b0, 8'h00, "rd8"});
        vt.push_back('{5'd9,  8'h00, 1'b0, 1'b1, 8'h00, "rst_drop"});
        vt.push_back('{5'd9,  8'h00, 1'b0, 1'b0, 8'hFF, "post_rst_a0"});
        vt.push_back('{5'd0,  8'h00, 1'b0, 1'b0, 8'hFF, "rd9_kept"});

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].a, vt[i].d, vt[i].w, vt[i].rst, vt[i].name);
            check({vt[i].name, "_tbl"}, q, vt[i].exp_q);
        end

        // Streaming: fill mem[i]=i^3C, then read 0..31 back to back.
        for (int i = 0; i < 32; i++) begin
            logic [7:0] v;
            v = 8'(i) ^ 8'h3C;
            step(5'(i), v, 1'b1, 1'b0, "fill");
        end
        for (int i = 0; i < 32; i++) begin
            step(5'(i), 8'h00, 1'b0, 1'b0, "stream");
            if (i > 0) check("stream_lag2", q, 8'(i - 1) ^ 8'h3C);
        end
        step(5'd0, 8'h00, 1'b0, 1'b0, "stream_tail");
        check("stream_last", q, 8'd31 ^ 8'h3C);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a;
            logic [7:0] d;
            logic       w, r;
            a = 5'($urandom_range(0, 31));
            d = 8'($urandom);
            w = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 31) == 0);
            step(a, d, w, r, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
